// File: rtl/cnn_mem_pkg.sv
// Shared definitions for the CNN parameter/image RAM arbiter.
// Contents: RAM geometry constants, arbiter FSM state encoding and the
// grant-side encoding used for round-robin bookkeeping.
package cnn_mem_pkg;

    localparam int RAM_ADDR_W  = 8;
    localparam int RAM_DATA_W  = 16;
    localparam int RAM_DEPTH   = 256;
    localparam int BURST_LEN_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        HOST_WR,
        HOST_RD,
        HOST_RD_WAIT,
        ENG_RD
    } arb_state_t;

    typedef enum logic {
        GNT_HOST,
        GNT_ENG
    } grant_t;

endpackage

// File: rtl/cnn_burst_seq.sv
// Burst sequencer for the CNN engine side of the RAM arbiter.
// Latches base/length on a start pulse, presents one beat request at a time
// to the arbiter (beat_req/beat_addr), counts issued beats (beat_issue) and
// returned beats (beat_ret), and produces eng_busy / eng_done.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   eng_start/base/len      burst command (ignored while busy)
//   eng_ready               engine back-pressure; gates new beat requests
//   beat_issue              arbiter granted the current beat this cycle
//   beat_ret                a read beat is returning to the engine this cycle
//   beat_req, beat_addr     pending beat and its RAM address
//   eng_busy, eng_done      burst in progress / one-cycle completion pulse
module cnn_burst_seq
    import cnn_mem_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int LEN_W  = BURST_LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              eng_start,
    input  logic [ADDR_W-1:0] eng_base,
    input  logic [LEN_W-1:0]  eng_len,
    input  logic              eng_ready,
    input  logic              beat_issue,
    input  logic              beat_ret,
    output logic              beat_req,
    output logic [ADDR_W-1:0] beat_addr,
    output logic              eng_busy,
    output logic              eng_done
);

    // A burst never needs more words than the RAM holds.
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  returned;

    assign beat_req  = eng_busy & eng_ready & (issued < len_q);
    // Truncation to ADDR_W gives the 0xFF -> 0x00 wrap.
    assign beat_addr = base_q + issued[ADDR_W-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q   <= '0;
            len_q    <= '0;
            issued   <= '0;
            returned <= '0;
            eng_busy <= 1'b0;
            eng_done <= 1'b0;
        end else begin
            eng_done <= 1'b0;
            if (!eng_busy) begin
                if (eng_start) begin
                    base_q   <= eng_base;
                    len_q    <= (eng_len > MAX_LEN) ? MAX_LEN : eng_len;
                    issued   <= '0;
                    returned <= '0;
                    eng_busy <= 1'b1;
                end
            end else begin
                if (beat_issue) issued   <= issued + LEN_W'(1);
                if (beat_ret)   returned <= returned + LEN_W'(1);
                // Zero-length bursts finish after their single busy cycle;
                // otherwise finish on the cycle the last beat returns so
                // done/busy-low land one cycle after the final rvalid.
                if (len_q == '0 || (beat_ret && (returned + LEN_W'(1)) == len_q)) begin
                    eng_busy <= 1'b0;
                    eng_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cnn_mem_arbiter.sv
// Single-port RAM controller shared by the HPS Avalon host and the CNN engine.
// Host: single-word read/write with waitrequest. Engine: burst reads driven
// by cnn_burst_seq. One access per grant; grants evaluated only in IDLE.
// Optional build macro CNN_ARB_HOST_PRIORITY_EN: host wins every tie (fixed
// priority, engine can starve); otherwise ties alternate round-robin.
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   host_*                           Avalon slave side (word addressed)
//   eng_start/base/len/ready         engine burst command + back-pressure
//   eng_busy/rvalid/rdata/done       engine burst status and read data
//   mem_cs/we/addr/wdata, mem_rdata  RAM port (1-cycle registered read)
module cnn_mem_arbiter
    import cnn_mem_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W,
    parameter int LEN_W  = BURST_LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              host_chipselect,
    input  logic              host_read,
    input  logic              host_write,
    input  logic [15:0]       host_address,
    input  logic [DATA_W-1:0] host_writedata,
    output logic [DATA_W-1:0] host_readdata,
    output logic              host_waitrequest,
    input  logic              eng_start,
    input  logic [ADDR_W-1:0] eng_base,
    input  logic [LEN_W-1:0]  eng_len,
    input  logic              eng_ready,
    output logic              eng_busy,
    output logic              eng_rvalid,
    output logic [DATA_W-1:0] eng_rdata,
    output logic              eng_done,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state;
    logic              host_pend;
    logic              host_oor;
    logic              host_oor_q;
    logic              rd_valid;
    logic              beat_req;
    logic [ADDR_W-1:0] beat_addr;
    logic              grant_host;
    logic              grant_eng;
`ifndef CNN_ARB_HOST_PRIORITY_EN
    grant_t            last_grant;
`endif

    assign host_pend = host_chipselect & (host_read | host_write);
    assign host_oor  = |host_address[15:ADDR_W];

    // RAM data is only meaningful in the cycle after a read; gate it so the
    // outputs read 0 otherwise (and for out-of-range host reads).
    assign host_readdata = rd_valid   ? mem_rdata : '0;
    assign eng_rdata     = eng_rvalid ? mem_rdata : '0;

    always_comb begin
        grant_host = 1'b0;
        grant_eng  = 1'b0;
        if (state == IDLE) begin
            if (host_pend && beat_req) begin
`ifdef CNN_ARB_HOST_PRIORITY_EN
                grant_host = 1'b1;
`else
                grant_host = (last_grant == GNT_ENG);
                grant_eng  = (last_grant == GNT_HOST);
`endif
            end else begin
                grant_host = host_pend;
                grant_eng  = beat_req;
            end
        end
    end

    cnn_burst_seq #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_seq (
        .clk        (clk),
        .reset_n    (reset_n),
        .eng_start  (eng_start),
        .eng_base   (eng_base),
        .eng_len    (eng_len),
        .eng_ready  (eng_ready),
        .beat_issue (grant_eng),
        .beat_ret   (eng_rvalid),
        .beat_req   (beat_req),
        .beat_addr  (beat_addr),
        .eng_busy   (eng_busy),
        .eng_done   (eng_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
`ifndef CNN_ARB_HOST_PRIORITY_EN
            last_grant       <= GNT_ENG;
`endif
            mem_cs           <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            host_waitrequest <= 1'b1;
            host_oor_q       <= 1'b0;
            rd_valid         <= 1'b0;
            eng_rvalid       <= 1'b0;
        end else begin
            mem_cs           <= 1'b0;
            mem_we           <= 1'b0;
            host_waitrequest <= 1'b1;
            rd_valid         <= 1'b0;
            eng_rvalid       <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_host) begin
`ifndef CNN_ARB_HOST_PRIORITY_EN
                        last_grant <= GNT_HOST;
`endif
                        mem_addr   <= host_address[ADDR_W-1:0];
                        mem_wdata  <= host_writedata;
                        host_oor_q <= host_oor;
                        // Out-of-range accesses keep normal timing but never
                        // touch the RAM.
                        mem_cs     <= ~host_oor;
                        if (host_write) begin
                            state            <= HOST_WR;
                            mem_we           <= ~host_oor;
                            host_waitrequest <= 1'b0;
                        end else begin
                            state <= HOST_RD;
                        end
                    end else if (grant_eng) begin
`ifndef CNN_ARB_HOST_PRIORITY_EN
                        last_grant <= GNT_ENG;
`endif
                        state    <= ENG_RD;
                        mem_cs   <= 1'b1;
                        mem_addr <= beat_addr;
                    end
                end
                HOST_WR: state <= IDLE;
                HOST_RD: begin
                    state            <= HOST_RD_WAIT;
                    host_waitrequest <= 1'b0;
                    rd_valid         <= ~host_oor_q;
                end
                HOST_RD_WAIT: state <= IDLE;
                ENG_RD: begin
                    state      <= IDLE;
                    eng_rvalid <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_mem_arbiter.sv
// Directed self-checking bench for cnn_mem_arbiter with a behavioural
// 256x16 registered-read RAM. Build with CNN_ARB_HOST_PRIORITY_EN defined to
// check the fixed-priority grant order instead of round-robin.
module tb_cnn_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        host_chipselect, host_read, host_write;
    logic [15:0] host_address, host_writedata, host_readdata;
    logic        host_waitrequest;
    logic        eng_start;
    logic [7:0]  eng_base;
    logic [8:0]  eng_len;
    logic        eng_ready;
    logic        eng_busy, eng_rvalid, eng_done;
    logic [15:0] eng_rdata;
    logic        mem_cs, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    int tests = 0;
    int fails = 0;

    cnn_mem_arbiter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .host_chipselect  (host_chipselect),
        .host_read        (host_read),
        .host_write       (host_write),
        .host_address     (host_address),
        .host_writedata   (host_writedata),
        .host_readdata    (host_readdata),
        .host_waitrequest (host_waitrequest),
        .eng_start        (eng_start),
        .eng_base         (eng_base),
        .eng_len          (eng_len),
        .eng_ready        (eng_ready),
        .eng_busy         (eng_busy),
        .eng_rvalid       (eng_rvalid),
        .eng_rdata        (eng_rdata),
        .eng_done         (eng_done),
        .mem_cs           (mem_cs),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous write, registered read.
    logic [15:0] ram [256];
    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    // Passive monitors.
    int          cyc = 0;
    int          cs_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_rv_cyc = 0;
    logic [15:0] beats[$];
    logic [7:0]  addrs[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (eng_rvalid) begin
            beats.push_back(eng_rdata);
            last_rv_cyc <= cyc;
        end
        if (eng_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (mem_cs) cs_cnt <= cs_cnt + 1;
        if (mem_cs && !mem_we) addrs.push_back(mem_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic last_we, last_cs;

    // One Avalon access, held until waitrequest drops; lat counts cycles
    // from the request cycle to the completion cycle.
    task automatic host_acc(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                            output logic [15:0] rdata, output int lat);
        host_chipselect = 1'b1;
        host_write      = wr;
        host_read       = !wr;
        host_address    = addr;
        host_writedata  = wdata;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (host_waitrequest && lat < 50);
        rdata   = host_readdata;
        last_we = mem_we;
        last_cs = mem_cs;
        host_chipselect = 1'b0;
        host_write      = 1'b0;
        host_read       = 1'b0;
        if (lat >= 50) chk("host_timeout", 32'(lat), 32'd0);
    endtask

    task automatic start_burst(input logic [7:0] base, input logic [8:0] len);
        eng_start = 1'b1;
        eng_base  = base;
        eng_len   = len;
        tick();
        eng_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (eng_done) seen = 1'b1;
            else tick();
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    logic [15:0] rd;
    int          lat, snap_b, snap_a, snap_cs, snap_done;

    initial begin
        reset_n = 1'b0;
        host_chipselect = 1'b0; host_read = 1'b0; host_write = 1'b0;
        host_address = '0; host_writedata = '0;
        eng_start = 1'b0; eng_base = '0; eng_len = '0; eng_ready = 1'b1;
        tick(2);

        // Reset state.
        chk("rst_waitreq", 32'(host_waitrequest), 32'd1);
        chk("rst_mem_cs",  32'(mem_cs), 32'd0);
        chk("rst_busy",    32'(eng_busy), 32'd0);
        chk("rst_rdata",   32'(host_readdata), 32'd0);
        reset_n = 1'b1;
        tick();

        // Host write then read.
        host_acc(1'b1, 16'h0010, 16'hBEEF, rd, lat);
        chk("wr_lat",  32'(lat), 32'd1);
        chk("wr_we",   32'(last_we), 32'd1);
        tick();
        host_acc(1'b0, 16'h0010, 16'h0, rd, lat);
        chk("rd_lat",  32'(lat), 32'd2);
        chk("rd_data", 32'(rd), 32'hBEEF);
        tick();

        // Preload 0..7 = k*3, then an 8-beat burst.
        for (int k = 0; k < 8; k++) begin
            host_acc(1'b1, 16'(k), 16'(k * 3), rd, lat);
            tick();
        end
        snap_b = beats.size();
        snap_done = done_cnt;
        start_burst(8'h00, 9'd8);
        chk("b8_busy", 32'(eng_busy), 32'd1);
        wait_done("b8_done_seen");
        chk("b8_busy_low", 32'(eng_busy), 32'd0);
        tick();
        chk("b8_count", 32'(beats.size() - snap_b), 32'd8);
        for (int k = 0; k < 8 && snap_b + k < beats.size(); k++)
            chk($sformatf("b8_beat%0d", k), 32'(beats[snap_b + k]), 32'(k * 3));
        chk("b8_done_gap", 32'(done_cyc - last_rv_cyc), 32'd1);
        chk("b8_done_cnt", 32'(done_cnt - snap_done), 32'd1);

        // Contention: host reads of 0x10 held back-to-back during a burst.
        snap_b = beats.size();
        snap_a = addrs.size();
        start_burst(8'h00, 9'd8);
        for (int r = 0; r < 3; r++) begin
            host_acc(1'b0, 16'h0010, 16'h0, rd, lat);
            chk($sformatf("ct_rd%0d", r), 32'(rd), 32'hBEEF);
        end
        wait_done("ct_done_seen");
        tick();
        chk("ct_count", 32'(beats.size() - snap_b), 32'd8);
        for (int k = 0; k < 8 && snap_b + k < beats.size(); k++)
            chk($sformatf("ct_beat%0d", k), 32'(beats[snap_b + k]), 32'(k * 3));
        begin
`ifdef CNN_ARB_HOST_PRIORITY_EN
            logic [7:0] exp_a [11] = '{8'h10, 8'h10, 8'h10, 8'h0, 8'h1, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6, 8'h7};
`else
            logic [7:0] exp_a [11] = '{8'h10, 8'h0, 8'h10, 8'h1, 8'h10, 8'h2, 8'h3, 8'h4, 8'h5, 8'h6, 8'h7};
`endif
            chk("ct_nacc", 32'(addrs.size() - snap_a), 32'd11);
            for (int k = 0; k < 11 && snap_a + k < addrs.size(); k++)
                chk($sformatf("ct_order%0d", k), 32'(addrs[snap_a + k]), 32'(exp_a[k]));
        end

        // Wrapping burst 0xFE..0x01.
        host_acc(1'b1, 16'h00FE, 16'h1111, rd, lat); tick();
        host_acc(1'b1, 16'h00FF, 16'h2222, rd, lat); tick();
        host_acc(1'b1, 16'h0000, 16'h3333, rd, lat); tick();
        host_acc(1'b1, 16'h0001, 16'h4444, rd, lat); tick();
        snap_b = beats.size();
        snap_a = addrs.size();
        start_burst(8'hFE, 9'd4);
        wait_done("wr_done_seen");
        tick();
        begin
            logic [7:0]  wa [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
            logic [15:0] wd [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
            chk("wrap_count", 32'(beats.size() - snap_b), 32'd4);
            for (int k = 0; k < 4 && snap_b + k < beats.size() && snap_a + k < addrs.size(); k++) begin
                chk($sformatf("wrap_addr%0d", k), 32'(addrs[snap_a + k]), 32'(wa[k]));
                chk($sformatf("wrap_data%0d", k), 32'(beats[snap_b + k]), 32'(wd[k]));
            end
        end

        // Zero-length burst.
        snap_cs = cs_cnt;
        start_burst(8'h20, 9'd0);
        chk("z_busy",  32'(eng_busy), 32'd1);
        tick();
        chk("z_done",  32'(eng_done), 32'd1);
        chk("z_idle",  32'(eng_busy), 32'd0);
        tick();
        chk("z_no_cs", 32'(cs_cnt - snap_cs), 32'd0);

        // Out-of-range host address.
        host_acc(1'b1, 16'h0100, 16'hDEAD, rd, lat);
        chk("oor_wr_lat", 32'(lat), 32'd1);
        chk("oor_wr_we",  32'(last_we), 32'd0);
        tick();
        host_acc(1'b0, 16'h0100, 16'h0, rd, lat);
        chk("oor_rd_lat",  32'(lat), 32'd2);
        chk("oor_rd_data", 32'(rd), 32'd0);
        tick();
        host_acc(1'b0, 16'h0000, 16'h0, rd, lat);
        chk("oor_alias", 32'(rd), 32'h3333);
        tick();

        // Reset in the middle of a burst.
        snap_b = beats.size();
        snap_done = done_cnt;
        start_burst(8'h00, 9'd8);
        for (int i = 0; i < 100 && (beats.size() - snap_b) < 3; i++) tick();
        chk("mr_3beats", 32'(beats.size() - snap_b), 32'd3);
        reset_n = 1'b0;
        #1;
        chk("mr_busy",    32'(eng_busy), 32'd0);
        chk("mr_cs",      32'(mem_cs), 32'd0);
        chk("mr_rvalid",  32'(eng_rvalid), 32'd0);
        chk("mr_waitreq", 32'(host_waitrequest), 32'd1);
        tick(2);
        reset_n = 1'b1;
        tick(3);
        chk("mr_no_done", 32'(done_cnt - snap_done), 32'd0);
        snap_b = beats.size();
        start_burst(8'h02, 9'd4);
        wait_done("mr_new_done");
        tick();
        chk("mr_new_count", 32'(beats.size() - snap_b), 32'd4);
        for (int k = 0; k < 4 && snap_b + k < beats.size(); k++)
            chk($sformatf("mr_new_beat%0d", k), 32'(beats[snap_b + k]), 32'((k + 2) * 3));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
